// File: rtl/stage_sequencer.sv
// Stage sequencer: drives an active-low one-hot stage enable for multi-cycle execution.
// It advances on done, skips masked stages, retires on wrap, and returns to stage 0 on fault or dwell timeout.
module stage_sequencer #(
    parameter int NUM_STAGES = 5,
    parameter int DWELL_W    = 8,
    parameter int TIMEOUT    = 200
) (
    input  logic                          clk,
    input  logic                          clear_n,
    input  logic                          done,
    input  logic                          stall,
    input  logic                          fault,
    input  logic [NUM_STAGES-1:0]         skip_mask,
    output logic [NUM_STAGES-1:0]         stage_n,
    output logic [$clog2(NUM_STAGES)-1:0] stage_idx,
    output logic                          retire,
    output logic                          timeout,
    output logic [DWELL_W-1:0]            dwell
);

    localparam int                 IDX_W      = $clog2(NUM_STAGES);
    localparam logic               TIMEOUT_EN = (TIMEOUT != 0);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(TIMEOUT - 1);
    localparam logic [DWELL_W-1:0] DWELL_MAX  = {DWELL_W{1'b1}};
    localparam logic [DWELL_W-1:0] DWELL_ONE  = {{(DWELL_W-1){1'b0}}, 1'b1};

    logic [IDX_W-1:0]      r_stage_idx;
    logic [NUM_STAGES-1:0] r_stage_n;
    logic                  r_retire;
    logic                  r_timeout;
    logic [DWELL_W-1:0]    r_dwell;

    logic [IDX_W:0]        w_next;
    logic                  w_timeout_hit;
    logic [IDX_W-1:0]      w_idx_d;
    logic [DWELL_W-1:0]    w_dwell_d;
    logic                  w_retire_d;
    logic                  w_timeout_d;

    // Returns {wrap, index}: the lowest unmasked stage above cur, or wrap=1 with index 0.
    function automatic logic [IDX_W:0] find_next(input logic [IDX_W-1:0] cur,
                                                 input logic [NUM_STAGES-1:0] mask);
        logic [IDX_W:0] res;
        res = {1'b1, {IDX_W{1'b0}}};
        for (int j = NUM_STAGES - 1; j >= 1; j--) begin
            if ((j > int'(cur)) && !mask[j]) begin
                res = {1'b0, IDX_W'(j)};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    function automatic logic [NUM_STAGES-1:0] onehot_n(input logic [IDX_W-1:0] idx);
        return ~({{(NUM_STAGES-1){1'b0}}, 1'b1} << idx);
    endfunction

    // Next-state selection in priority order: fault, timeout, stall, done, hold.
    always_comb begin
        w_next        = find_next(r_stage_idx, skip_mask);
        w_timeout_hit = TIMEOUT_EN && !stall && !fault && !done && (r_dwell == DWELL_LAST);
        w_idx_d       = r_stage_idx;
        w_dwell_d     = r_dwell;
        w_retire_d    = 1'b0;
        w_timeout_d   = 1'b0;
        if (fault) begin
            w_idx_d   = {IDX_W{1'b0}};
            w_dwell_d = {DWELL_W{1'b0}};
        end else if (w_timeout_hit) begin
            w_idx_d     = {IDX_W{1'b0}};
            w_dwell_d   = {DWELL_W{1'b0}};
            w_timeout_d = 1'b1;
        end else if (stall) begin
            w_idx_d   = r_stage_idx;
            w_dwell_d = r_dwell;
        end else if (done) begin
            w_idx_d    = w_next[IDX_W-1:0];
            w_dwell_d  = {DWELL_W{1'b0}};
            w_retire_d = w_next[IDX_W];
        end else if (r_dwell != DWELL_MAX) begin
            w_dwell_d = r_dwell + DWELL_ONE;
        end else begin
            w_dwell_d = r_dwell;
        end
    end

    // State and output registers; the one-hot vector is re-derived from the index so they never disagree.
    always_ff @(posedge clk) begin
        if (!clear_n) begin
            r_stage_idx <= {IDX_W{1'b0}};
            r_stage_n   <= onehot_n({IDX_W{1'b0}});
            r_retire    <= 1'b0;
            r_timeout   <= 1'b0;
            r_dwell     <= {DWELL_W{1'b0}};
        end else begin
            r_stage_idx <= w_idx_d;
            r_stage_n   <= onehot_n(w_idx_d);
            r_retire    <= w_retire_d;
            r_timeout   <= w_timeout_d;
            r_dwell     <= w_dwell_d;
        end
    end

    assign stage_n   = r_stage_n;
    assign stage_idx = r_stage_idx;
    assign retire    = r_retire;
    assign timeout   = r_timeout;
    assign dwell     = r_dwell;

endmodule
